// File: rtl/bit_enum_pkg.sv
// rtl/bit_enum_pkg.sv - shared constants, state enum and mask helpers for the set-bit enumerator
package bit_enum_pkg;

    localparam int WIDTH = 64;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Removes the lowest set bit: the classic v & (v - 1) trick.
    function automatic logic [WIDTH-1:0] clear_lowest(input logic [WIDTH-1:0] v);
        return v & (v - WIDTH'(1));
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        return (v != '0) && (clear_lowest(v) == '0);
    endfunction

endpackage

// File: rtl/bit_idx_enum_if.sv
// rtl/bit_idx_enum_if.sv - index output stream with valid/ready handshake
interface bit_idx_enum_if;
    import bit_enum_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - combinational lowest-set-bit priority encoder
module lsb_prio_enc #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last writer and wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_idx_enum.sv
// rtl/bit_idx_enum.sv - streams the index of every set bit of a captured mask, LSB first
module bit_idx_enum
    import bit_enum_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mask_in,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count,
    bit_idx_enum_if.master     out_if
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [IDX_W-1:0]   low_idx;
    logic               low_any;
    logic               low_last;
    logic               accept;

    lsb_prio_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec (shadow_q),
        .idx (low_idx),
        .any (low_any)
    );

    // Outputs depend only on registers, so out_ready only ever feeds state.
    assign low_last = single_bit(shadow_q);
    assign accept   = (state_q == SCAN) && low_any && out_if.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an empty shadow in SCAN (empty mask) falls straight through to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!low_any) begin
                    state_d = DONE;
                end else if (accept && low_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow and counter next values: capture on start, peel one bit per accept.
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if ((state_q == IDLE) && start) begin
            shadow_d = mask_in;
            count_d  = '0;
        end else if (accept) begin
            shadow_d = clear_lowest(shadow_q);
            count_d  = count_q + CNT_W'(1);
        end
    end

    // Shadow and counter registers; a reset drops any partially walked mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    // Output decode from state and shadow.
    always_comb begin
        out_if.out_valid = 1'b0;
        out_if.out_idx   = '0;
        out_if.out_last  = 1'b0;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        count            = count_q;
        if (state_q == SCAN) begin
            out_if.out_valid = low_any;
            out_if.out_idx   = low_idx;
            out_if.out_last  = low_last;
        end
    end

endmodule

// File: doc/bit_idx_enum.md
Name: bit_idx_enum

Overview:
Sequential set-bit enumerator: the inverse direction of the bit_cntr popcount. bit_cntr collapses a 64-bit mask to a count. This block captures a 64-bit mask and streams out the index of every set bit, LSB first, one per accepted transfer, under valid/ready handshake. On completion it reports the total count. It is used to walk active-voice/key masks in the synth.

Parameters:
WIDTH, 64, mask width in bits.
IDX_W, 6, index width (clog2 WIDTH).
CNT_W, 7, count width (clog2 WIDTH + 1, so it can hold WIDTH).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  capture mask_in and begin enumeration; honoured only in IDLE.
mask_in  in  WIDTH  mask to enumerate, sampled on the start edge.
busy  out  1  high from the cycle after start is accepted until the cycle after done.
out_valid  out  1  out_idx is valid.
out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
out_idx  out  IDX_W  index of the lowest remaining set bit.
out_last  out  1  the current index is the final set bit.
done  out  1  one-cycle pulse at the end of enumeration.
count  out  CNT_W  number of indices accepted; held until the next start.

Behaviour:
- Reset (asynchronous, any time, including mid-stream): state=IDLE, shadow=0, busy=0, out_valid=0, out_idx=0, out_last=0, done=0, count=0. No partial output resumes after reset.
- States: IDLE, SCAN, DONE.
- IDLE: on a clock edge with start=1, shadow<=mask_in, count<=0, state<=SCAN.
- start while in SCAN or DONE is ignored. mask_in changes after capture have no effect.
- SCAN outputs are combinational from registers only; there is no combinational input-to-output path.
  - out_valid = (shadow != 0).
  - out_idx = lowest set bit position of shadow.
  - out_last = 1 when shadow has exactly one bit set.
- Handshake rules:
  - out_valid, once high, stays high with out_idx and out_last stable until accepted.
  - out_ready may toggle freely.
  - Accept: clear the lowest set bit of shadow and increment count, both on the same edge.
  - Throughput is one index per cycle when out_ready is held high.
- SCAN to DONE transitions:
  - On the edge accepting the out_last transfer, state<=DONE.
  - If shadow==0 on entry to SCAN (empty mask), state<=DONE on the next edge with no out_valid ever asserted.
- DONE: done=1 for exactly one cycle, busy still 1, count final. The next edge goes to IDLE.
- Latency:
  - First out_valid is in the cycle after the start edge.
  - done is in the cycle after the last accept.
  - For an empty mask, done is 2 cycles after the start edge.
- Width and arithmetic:
  - count never wraps: maximum is WIDTH=64, which fits in 7 bits.
  - The final count equals the bit_cntr output for the same mask.
- Bit 63 and bit 0 are handled identically; there is no index wrap.

Decomposition:
- Shared package bit_enum_pkg holds:
  - constants WIDTH, IDX_W, CNT_W;
  - the state enum {IDLE, SCAN, DONE}.
- One sub-module, lsb_prio_enc (parameter WIDTH):
  - combinational lowest-set-bit priority encoder;
  - outputs idx[IDX_W] and any;
  - lowest index wins.
- The top level contains the FSM, shadow register, counter and handshake.

Test Plan:
- mask 0x4A, out_ready=1: start, then out_idx 1,3,6 on three consecutive cycles; out_last only with 6; done next cycle; count=3.
- mask 0: start, then out_valid never high; done pulses 2 cycles after the start edge; count=0; busy high for 2 cycles.
- mask 0x3000004A with out_ready pseudo-random: sequence 1,3,6,28,29; out_idx and out_last stable while out_ready=0; count=5.
- mask all-ones: 64 transfers, idx 0..63 in order; out_last at 63; count=64 (7'h40); 64 cycles start-to-last with ready=1.
- mask 0x8000000000000000: single transfer idx=63 with out_last=1; count=1.
- Robustness, both checked for all masks and compared against bit_cntr:
  - start pulsed mid-stream is ignored, sequence unchanged;
  - rst_n low after the 2nd transfer of 0x4A clears everything immediately; a fresh start with 0x81 yields 0,7, count=2.
